// File: rtl/exm_wb_if.sv
// EX/MEM -> WB bus bundle: upstream handshake and fields, downstream writeback/forwarding view.
// EXM_WB_CSR_EN adds csr_rdata to the bundle.
interface exm_wb_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] dmem_rdata;
    logic [2:0]      LDSel;
    logic [1:0]      WBSel;
    logic            RegWen;
    logic [31:0]     Inst;
`ifdef EXM_WB_CSR_EN
    logic [XLEN-1:0] csr_rdata;
`endif
    logic            out_valid;
    logic            out_ready;
    logic            wb_wen;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [XLEN-1:0] wb_pc;
    logic            fwd_en;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;

`ifdef EXM_WB_CSR_EN
    modport master (
        output flush, in_valid, pc, alu, dmem_rdata, LDSel, WBSel, RegWen, Inst, csr_rdata, out_ready,
        input  in_ready, out_valid, wb_wen, wb_rd, wb_data, wb_pc, fwd_en, fwd_rd, fwd_data
    );
    modport slave (
        input  flush, in_valid, pc, alu, dmem_rdata, LDSel, WBSel, RegWen, Inst, csr_rdata, out_ready,
        output in_ready, out_valid, wb_wen, wb_rd, wb_data, wb_pc, fwd_en, fwd_rd, fwd_data
    );
`else
    modport master (
        output flush, in_valid, pc, alu, dmem_rdata, LDSel, WBSel, RegWen, Inst, out_ready,
        input  in_ready, out_valid, wb_wen, wb_rd, wb_data, wb_pc, fwd_en, fwd_rd, fwd_data
    );
    modport slave (
        input  flush, in_valid, pc, alu, dmem_rdata, LDSel, WBSel, RegWen, Inst, out_ready,
        output in_ready, out_valid, wb_wen, wb_rd, wb_data, wb_pc, fwd_en, fwd_rd, fwd_data
    );
`endif
endinterface

// File: rtl/exm_wb_regs.sv
// EX/MEM -> WB pipeline register with 2-entry skid buffer, load extension and WB/forward mux.
// Optional macro EXM_WB_CSR_EN: carries csr_rdata and selects it for WBSel=3.
module exm_wb_regs #(
    parameter int              XLEN   = 32,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    exm_wb_if.slave   bus
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] dmem;
`ifdef EXM_WB_CSR_EN
        logic [XLEN-1:0] csr;
`endif
        logic [2:0]      ldsel;
        logic [1:0]      wbsel;
        logic            regwen;
        logic [4:0]      rd;
    } entry_t;

    function automatic entry_t entry_rst();
        entry_t e;
        e    = '0;
        e.pc = RST_PC;
        return e;
    endfunction

    // Byte lane from alu[1:0], half lane from alu[1]; unknown selectors fall back to lw.
    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] word,
                                                 input logic [1:0]      off,
                                                 input logic [2:0]      sel);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sel)
            3'd0:    load_ext = {{(XLEN-8){b[7]}}, b};
            3'd1:    load_ext = {{(XLEN-16){h[15]}}, h};
            3'd3:    load_ext = {{(XLEN-8){1'b0}}, b};
            3'd4:    load_ext = {{(XLEN-16){1'b0}}, h};
            default: load_ext = word;
        endcase
    endfunction

    logic [1:0] state, state_nxt;
    logic       in_ready_r;
    entry_t     main_p1, skid_p1, in_p0;
    logic       load_main, load_skid, main_from_skid;
    logic       accept, drain, out_valid_w;

    always_comb begin
        in_p0        = '0;
        in_p0.pc     = bus.pc;
        in_p0.alu    = bus.alu;
        in_p0.dmem   = bus.dmem_rdata;
`ifdef EXM_WB_CSR_EN
        in_p0.csr    = bus.csr_rdata;
`endif
        in_p0.ldsel  = bus.LDSel;
        in_p0.wbsel  = bus.WBSel;
        in_p0.regwen = bus.RegWen;
        in_p0.rd     = bus.Inst[11:7];
    end

    assign out_valid_w = (state != EMPTY);
    assign accept      = bus.in_valid & in_ready_r;
    assign drain       = out_valid_w & bus.out_ready;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    load_main = 1'b1;
                    state_nxt = HALF;
                end
                HALF: begin
                    if (accept && drain) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        load_skid = 1'b1;
                        state_nxt = FULL;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: if (drain) begin
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = HALF;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Stage p0 -> p1: main/skid capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_r <= 1'b1;
            main_p1    <= entry_rst();
            skid_p1    <= entry_rst();
        end else begin
            state      <= state_nxt;
            in_ready_r <= (state_nxt != FULL);
            if (load_main) main_p1 <= main_from_skid ? skid_p1 : in_p0;
            if (load_skid) skid_p1 <= in_p0;
        end
    end

    logic [XLEN-1:0] sel_data;
    logic            wen_w;

    always_comb begin
        case (main_p1.wbsel)
            2'd0:    sel_data = load_ext(main_p1.dmem, main_p1.alu[1:0], main_p1.ldsel);
            2'd1:    sel_data = main_p1.alu;
            2'd2:    sel_data = main_p1.pc + XLEN'(4);
`ifdef EXM_WB_CSR_EN
            default: sel_data = main_p1.csr;
`else
            default: sel_data = '0;
`endif
        endcase
    end

    // Stage p1 outputs: everything gated by the main valid
    assign wen_w         = out_valid_w & main_p1.regwen & (main_p1.rd != 5'd0);
    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_w;
    assign bus.wb_wen    = wen_w;
    assign bus.wb_rd     = out_valid_w ? main_p1.rd : 5'd0;
    assign bus.wb_data   = out_valid_w ? sel_data : '0;
    assign bus.wb_pc     = out_valid_w ? main_p1.pc : '0;
    assign bus.fwd_en    = wen_w;
    assign bus.fwd_rd    = out_valid_w ? main_p1.rd : 5'd0;
    assign bus.fwd_data  = out_valid_w ? sel_data : '0;
endmodule

// File: tb/tb_exm_wb_regs.sv
// Bench for exm_wb_regs: queue-based reference model, per-cycle compare and directed literal cases.
module tb_exm_wb_regs;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exm_wb_if #(.XLEN(XLEN)) bus ();
  exm_wb_regs #(.XLEN(XLEN), .RST_PC('0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dmem;
    logic [31:0] inst;
    logic [31:0] csr;
    logic [2:0]  ldsel;
    logic [1:0]  wbsel;
    logic        regwen;
  } txn_t;

  txn_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input txn_t t);
    int unsigned b, h;
    b = (t.dmem >> (8 * (t.alu % 4))) & 32'hFF;
    h = (t.dmem >> (16 * ((t.alu / 2) % 2))) & 32'hFFFF;
    case (t.wbsel)
      2'd0: case (t.ldsel)
        3'd0: return (b >= 128) ? b - 256 : b;
        3'd1: return (h >= 32768) ? h - 65536 : h;
        3'd3: return b;
        3'd4: return h;
        default: return t.dmem;
      endcase
      2'd1: return t.alu;
      2'd2: return t.pc + 32'd4;
`ifdef EXM_WB_CSR_EN
      default: return t.csr;
`else
      default: return 32'd0;
`endif
    endcase
  endfunction

  function automatic txn_t cur_in();
    txn_t t;
    t.pc = bus.pc;
    t.alu = bus.alu;
    t.dmem = bus.dmem_rdata;
    t.inst = bus.Inst;
`ifdef EXM_WB_CSR_EN
    t.csr = bus.csr_rdata;
`else
    t.csr = 32'd0;
`endif
    t.ldsel = bus.LDSel;
    t.wbsel = bus.WBSel;
    t.regwen = bus.RegWen;
    return t;
  endfunction

  // Reference: a 2-deep FIFO; pop on drain, push on accept, flush empties it
  always @(posedge clk or negedge rst_n) begin
    bit acc, drn;
    if (!rst_n) begin
      q.delete();
    end else if (bus.flush) begin
      q.delete();
    end else begin
      acc = bus.in_valid && (q.size() < 2);
      drn = (q.size() > 0) && bus.out_ready;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(cur_in());
    end
  end

  always @(negedge clk) begin
    txn_t t;
    logic [4:0] rd;
    logic wen;
    logic [31:0] d;
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      t = q[0];
      rd = t.inst[11:7];
      wen = t.regwen && (rd != 5'd0);
      d = exp_data(t);
      chk("wb_wen", bus.wb_wen, wen);
      chk("wb_rd", bus.wb_rd, rd);
      chk("wb_data", bus.wb_data, d);
      chk("wb_pc", bus.wb_pc, t.pc);
      chk("fwd_en", bus.fwd_en, wen);
      chk("fwd_rd", bus.fwd_rd, rd);
      chk("fwd_data", bus.fwd_data, d);
    end else begin
      chk("idle_outs", {bus.wb_wen, bus.wb_rd, bus.wb_data, bus.fwd_en, bus.fwd_rd}, 64'd0);
      chk("idle_data", {bus.wb_pc, bus.fwd_data}, 64'd0);
    end
  end

  task automatic idle();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.pc = '0;
    bus.alu = '0;
    bus.dmem_rdata = '0;
    bus.LDSel = '0;
    bus.WBSel = '0;
    bus.RegWen = 1'b0;
    bus.Inst = '0;
`ifdef EXM_WB_CSR_EN
    bus.csr_rdata = '0;
`endif
  endtask

  task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] dmem,
                      input logic [2:0] ld, input logic [1:0] wb, input logic wen, input logic [4:0] rd);
    logic [31:0] i;
    i = $urandom;
    i[11:7] = rd;
    bus.in_valid = 1'b1;
    bus.pc = pc;
    bus.alu = alu;
    bus.dmem_rdata = dmem;
    bus.LDSel = ld;
    bus.WBSel = wb;
    bus.RegWen = wen;
    bus.Inst = i;
  endtask

  initial begin
    logic [31:0] i;
    idle();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_wb_wen", {bus.wb_wen, bus.fwd_en}, 2'b00);
    rst_n = 1'b1;

    @(negedge clk);
    send(32'h0, 32'h1234, 32'h0, 3'd0, 2'd1, 1'b1, 5'd5);
    @(negedge clk);
    chk("alu_wen", bus.wb_wen, 1'b1);
    chk("alu_rd", bus.wb_rd, 5'd5);
    chk("alu_data", bus.wb_data, 32'h1234);
    send(32'h40, 32'h1001, 32'h80FF7F01, 3'd0, 2'd0, 1'b1, 5'd7);
    @(negedge clk);
    chk("lb_lane1", bus.wb_data, 32'h0000007F);
    send(32'h44, 32'h1002, 32'h80FF7F01, 3'd1, 2'd0, 1'b1, 5'd7);
    @(negedge clk);
    chk("lh_upper", bus.wb_data, 32'hFFFF80FF);
    send(32'h48, 32'h1002, 32'h80FF7F01, 3'd4, 2'd0, 1'b1, 5'd7);
    @(negedge clk);
    chk("lhu_upper", bus.wb_data, 32'h000080FF);
    send(32'h4C, 32'h1003, 32'h80FF7F01, 3'd6, 2'd0, 1'b1, 5'd7);
    @(negedge clk);
    chk("ld6_as_lw", bus.wb_data, 32'h80FF7F01);
    send(32'hFFFFFFFC, 32'h0, 32'h0, 3'd0, 2'd2, 1'b1, 5'd3);
    @(negedge clk);
    chk("pc4_wrap", bus.wb_data, 32'h0);
    chk("pc4_wen", bus.wb_wen, 1'b1);
    send(32'h50, 32'hABCD, 32'h0, 3'd0, 2'd1, 1'b1, 5'd0);
    @(negedge clk);
    chk("rd0_valid", bus.out_valid, 1'b1);
    chk("rd0_wen", {bus.wb_wen, bus.fwd_en}, 2'b00);
    send(32'h54, 32'h0, 32'h0, 3'd0, 2'd3, 1'b1, 5'd9);
`ifdef EXM_WB_CSR_EN
    bus.csr_rdata = 32'hC5C5_0001;
    @(negedge clk);
    chk("wbsel3", bus.wb_data, 32'hC5C5_0001);
`else
    @(negedge clk);
    chk("wbsel3", bus.wb_data, 32'h0);
`endif
    chk("wbsel3_wen", bus.wb_wen, 1'b1);
    idle();

    // Stall: A,B fill the buffer, C waits, then drains in order
    @(negedge clk);
    bus.out_ready = 1'b0;
    send(32'h100, 32'h0, 32'h0, 3'd0, 2'd2, 1'b1, 5'd1);
    @(negedge clk);
    chk("stall_rdy_a", bus.in_ready, 1'b1);
    send(32'h104, 32'h0, 32'h0, 3'd0, 2'd2, 1'b1, 5'd2);
    @(negedge clk);
    chk("stall_rdy_b", bus.in_ready, 1'b0);
    chk("stall_hold_a", bus.wb_pc, 32'h100);
    send(32'h108, 32'h0, 32'h0, 3'd0, 2'd2, 1'b1, 5'd3);
    @(negedge clk);
    chk("stall_c_blocked", bus.in_ready, 1'b0);
    chk("stall_hold_a2", bus.wb_pc, 32'h100);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("order_b", bus.wb_pc, 32'h104);
    @(negedge clk);
    chk("order_c", bus.wb_pc, 32'h108);
    chk("order_c_data", bus.wb_data, 32'h10C);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("order_empty", bus.out_valid, 1'b0);

    // Flush while FULL with a new input presented
    bus.out_ready = 1'b0;
    send(32'h200, 32'h0, 32'h0, 3'd0, 2'd1, 1'b1, 5'd4);
    @(negedge clk);
    send(32'h204, 32'h0, 32'h0, 3'd0, 2'd1, 1'b1, 5'd4);
    @(negedge clk);
    chk("flush_full", bus.in_ready, 1'b0);
    send(32'h208, 32'h0, 32'h0, 3'd0, 2'd1, 1'b1, 5'd4);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_ready", bus.in_ready, 1'b1);
    idle();
    @(negedge clk);
    chk("flush_no_capture", bus.out_valid, 1'b0);

    // Async reset while FULL
    bus.out_ready = 1'b0;
    send(32'h300, 32'h5, 32'h0, 3'd0, 2'd1, 1'b1, 5'd6);
    @(negedge clk);
    send(32'h304, 32'h6, 32'h0, 3'd0, 2'd1, 1'b1, 5'd6);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", bus.out_valid, 1'b0);
    chk("rst_mid_ready", bus.in_ready, 1'b1);
    chk("rst_mid_data", bus.wb_data, 32'h0);
    rst_n = 1'b1;
    idle();

    repeat (3000) begin
      @(negedge clk);
      bus.in_valid = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.flush = ($urandom % 40) == 0;
      bus.pc = $urandom;
      bus.alu = $urandom;
      bus.dmem_rdata = $urandom;
      bus.LDSel = 3'($urandom % 8);
      bus.WBSel = 2'($urandom % 4);
      bus.RegWen = 1'($urandom % 2);
      i = $urandom;
      if ($urandom % 8 == 0) i[11:7] = 5'd0;
      bus.Inst = i;
`ifdef EXM_WB_CSR_EN
      bus.csr_rdata = $urandom;
`endif
    end
    idle();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
